// File: rtl/mem_arbiter_n.sv
// N-port cacheline arbiter in front of a single cacheline adaptor.
// Each grant is latched so the adaptor sees stable signals for the whole transaction.

module mem_arb_port (
    input  logic read,
    input  logic write,
    output logic active,
    output logic is_write
);
    // Write takes precedence when a port raises both strobes.
    assign active   = read | write;
    assign is_write = write;
endmodule

module mem_arbiter_n #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter int MODE       = 0,
    localparam int GW        = $clog2(NUM_PORTS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_PORTS-1:0]                   req_read,
    input  logic [NUM_PORTS-1:0]                   req_write,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   req_address,
    input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]                   req_resp,
    output logic [LINE_WIDTH-1:0]                  req_rdata,
    output logic                                   mem_read,
    output logic                                   mem_write,
    output logic [ADDR_WIDTH-1:0]                  mem_address,
    output logic [LINE_WIDTH-1:0]                  mem_wdata,
    input  logic                                   mem_resp,
    input  logic [LINE_WIDTH-1:0]                  mem_rdata,
    output logic [GW-1:0]                          grant,
    output logic                                   busy
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_n;
    logic [GW-1:0]        rr_ptr;
    logic [NUM_PORTS-1:0] active, wr_sel;
    logic [GW-1:0]        pick;
    logic                 take, done;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        mem_arb_port u_port (
            .read    (req_read[p]),
            .write   (req_write[p]),
            .active  (active[p]),
            .is_write(wr_sel[p])
        );
    end

    // Scan from rr_ptr (or from 0 in fixed priority), wrapping; first requester wins.
    always_comb begin
        logic [GW:0]   sum;
        logic [GW-1:0] idx;
        logic          found;
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (MODE == 1) begin
                idx = GW'(i);
            end else begin
                sum = {1'b0, rr_ptr} + (GW+1)'(i);
                if (sum >= (GW+1)'(NUM_PORTS))
                    sum = sum - (GW+1)'(NUM_PORTS);
                idx = sum[GW-1:0];
            end
            if (!found && active[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        take    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (|active) begin
                take    = 1'b1;
                state_n = BUSY;
            end
            BUSY: if (mem_resp) begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant       <= '0;
            rr_ptr      <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            if (take) begin
                grant       <= pick;
                mem_write   <= wr_sel[pick];
                mem_read    <= ~wr_sel[pick];
                mem_address <= req_address[pick];
                mem_wdata   <= req_wdata[pick];
            end
            if (done) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
                if (MODE == 0)
                    rr_ptr <= (grant == GW'(NUM_PORTS-1)) ? '0 : grant + GW'(1);
            end
        end
    end

    always_comb begin
        req_resp = '0;
        if (done) req_resp[grant] = 1'b1;
    end

    assign req_rdata = mem_rdata;
    assign busy      = (state == BUSY);

endmodule
